mult_top: RTL and testbench

//  Sequential unsigned fixed-point shift-add multiplier; inverse-operation companion to the divider.

---
 rtl/mult_top.sv | 162 ++++++++++++++++
 tb/tb_mult_top.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mult_top.sv
// -----------------------------------------------------------------------------
// mult_top: sequential unsigned fixed-point shift-add multiplier.
//
// Computes Q = (A * B) >> FRAC, consuming one multiplier bit per clock. The
// start/busy/valid/ov handshake matches the companion divider, so one controller
// can drive both blocks.
//
// Timing: a start accepted at edge N holds busy high through edge N+WIDTH. At
// edge N+WIDTH+1, Q/ov are updated and valid pulses for one cycle. A start that
// arrives while busy, or during the DONE cycle, is dropped.
//
// Configuration macro:
//   MULT_ROUND_EN  When defined and FRAC > 0, the result is rounded half-up
//                  instead of truncated. A carry out of the result field from
//                  this rounding also sets ov.
//
// Parameters:
//   WIDTH  operand/result width in bits
//   FRAC   fractional bits in A, B and Q (0 <= FRAC < WIDTH)
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous, active-high reset
//   start  in   1      operation request, sampled only when idle
//   A      in   WIDTH  multiplicand, latched on accepted start
//   B      in   WIDTH  multiplier, latched on accepted start
//   Q      out  WIDTH  result; holds the last completed value
//   busy   out  1      high while the shift-add loop runs
//   valid  out  1      one-cycle pulse when Q/ov are updated
//   ov     out  1      result does not fit in WIDTH bits; valid with Q
// -----------------------------------------------------------------------------
module mult_top #(
    parameter int WIDTH = 10,
    parameter int FRAC  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             valid,
    output logic             ov
);

    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [PW-1:0]    mcand;
    logic [WIDTH-1:0] mplr;
    logic [PW-1:0]    acc;
    logic [CNT_W-1:0] cnt;

    logic [PW-1:0]    rounded;
    logic [WIDTH-1:0] q_next;
    logic             ov_next;

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next-state logic
    // -------------------------------------------------------------------------
    // NOTE: assigning state_next a default before the case means every path
    // drives it, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (cnt == LAST_CNT) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    // -------------------------------------------------------------------------
    // Result formatting: optional round-half-up ahead of the field select.
    // The sum cannot overflow PW bits, because (2^W-1)^2 + 2^(FRAC-1) < 2^(2W).
    // -------------------------------------------------------------------------
`ifdef MULT_ROUND_EN
    generate
        if (FRAC > 0) begin : g_round
            localparam logic [PW-1:0] HALF = PW'(1) << (FRAC - 1);
            assign rounded = acc + HALF;
        end else begin : g_no_round
            assign rounded = acc;
        end
    endgenerate
`else
    assign rounded = acc;
`endif

    assign q_next  = rounded[FRAC+WIDTH-1:FRAC];
    assign ov_next = |rounded[PW-1:FRAC+WIDTH];

    // -------------------------------------------------------------------------
    // Datapath: operand latch, shift-add loop, result/flag registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments. All flops then
    // update together from the values that were present before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: every datapath register is reset. There is no memory array
            // here, and a reset during a run must leave Q/ov reading zero.
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            Q     <= '0;
            ov    <= 1'b0;
            valid <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= {{WIDTH{1'b0}}, A};
                        mplr  <= B;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (mplr[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + 1'b1;
                end
                DONE: begin
                    Q     <= q_next;
                    ov    <= ov_next;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_top.sv
// -----------------------------------------------------------------------------
// tb_mult_top: self-checking bench for mult_top (WIDTH=10, FRAC=5).
//
// The driver pushes the expected result onto a scoreboard queue each time a
// start is accepted. The acceptance edge comes from the handshake timing rule,
// not from reading the DUT. A negedge monitor pops the queue on every valid
// and checks Q, ov and latency. On every cycle it also checks busy against the
// expected busy window.
// -----------------------------------------------------------------------------
module tb_mult_top;

    localparam int W = 10;
    localparam int F = 5;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic         busy;
    logic         valid;
    logic         ov;

    always #5 clk = ~clk;

    mult_top #(.WIDTH(W), .FRAC(F)) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (a),
        .B    (b),
        .Q    (q),
        .busy (busy),
        .valid(valid),
        .ov   (ov)
    );

    typedef struct {
        logic [W-1:0] q;
        logic         ov;
        int           acc_edge;
    } exp_t;

    exp_t         exp_q[$];
    int           n_cmp       = 0;
    int           n_bad       = 0;
    int           cyc         = 0;   // number of posedges so far
    int           next_free   = 0;   // first edge at which a start is accepted
    int           last_accept = -100;
    int           reset_edge  = 0;
    logic [W-1:0] last_q      = '0;
    logic         last_ov     = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference model: exact fixed-point product with plain integer arithmetic.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input int e);
        exp_t   r;
        longint p;
        longint s;
        p = longint'(x) * longint'(y);
`ifdef MULT_ROUND_EN
        if (F > 0) p = p + (longint'(1) << (F - 1));
`endif
        s = p >>> F;
        r.q        = W'(s % (longint'(1) << W));
        r.ov       = (s >= (longint'(1) << W));
        r.acc_edge = e;
        return r;
    endfunction

    task automatic accept(input int e);
        exp_q.push_back(model(a, b, e));
        last_accept = e;
        next_free   = e + W + 2;
    endtask

    // One start pulse, issued when the handshake rule says the DUT is idle.
    // Operands are scrambled after the pulse to show that they were latched.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv);
        @(negedge clk);
        while (cyc + 1 < next_free) @(negedge clk);
        a     = av;
        b     = bv;
        start = 1'b1;
        accept(cyc + 1);
        @(negedge clk);
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || cyc < next_free) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: busy window every cycle, plus the scoreboard pop on valid.
    always @(negedge clk) begin
        exp_t e;
        logic eb;
        if (cyc >= 1) begin
            eb = (cyc >= last_accept) && (cyc <= last_accept + W - 1) &&
                 !((reset_edge > last_accept) && (cyc >= reset_edge));
            check("busy", busy, eb);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL valid_unexpected: got valid=1 expected 0 (t=%0t)", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("q", q, e.q);
                    check("ov", ov, e.ov);
                    check("latency", cyc, e.acc_edge + W + 1);
                    last_q  = e.q;
                    last_ov = e.ov;
                end
            end
        end
    end

    initial begin
        int e0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_q", q, 0);
        check("rst_ov", ov, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        rst       = 1'b0;
        next_free = cyc + 1;

        // Directed corner cases
        issue(10'd32, 10'd96);     // 1.0 * 3.0
        issue(10'd1023, 10'd1023); // overflow
        issue(10'd1, 10'd16);      // sub-LSB product: rounding boundary
        issue(10'd0, 10'd1023);
        issue(10'd1023, 10'd0);
        drain();

        // Random operations, some back-to-back and some with idle gaps
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(W'($urandom), W'($urandom));
        end
        drain();

        // start held high for 20 cycles while operands keep changing
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            a     = W'($urandom);
            b     = W'($urandom);
            start = 1'b1;
            if (cyc + 1 >= next_free) accept(cyc + 1);
            @(negedge clk);
        end
        start = 1'b0;
        drain();

        // Reset during the 4th RUN cycle aborts the operation
        @(negedge clk);
        while (cyc + 1 < next_free) @(negedge clk);
        a     = 10'd517;
        b     = 10'd333;
        start = 1'b1;
        accept(cyc + 1);
        e0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        while (cyc + 1 < e0 + 4) @(negedge clk);
        rst        = 1'b1;
        reset_edge = cyc + 1;
        exp_q.delete();
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_q", q, 0);
        check("abort_ov", ov, 0);
        rst       = 1'b0;
        next_free = cyc + 1;
        last_q    = '0;
        last_ov   = 1'b0;
        repeat (20) @(negedge clk);  // the monitor flags any stray valid
        issue(10'd64, 10'd80);       // 2.0 * 2.5
        drain();

        // Hold: outputs stay put while operands toggle with start low
        for (int i = 0; i < 50; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            @(negedge clk);
            check("hold_q", q, last_q);
            check("hold_ov", ov, last_ov);
            check("hold_valid", valid, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
